dff_sample_fifo: RTL and testbench

Synchronous FIFO that buffers the 4-bit samples produced by the team's `dff` capture register and hands them downstream under a valid/ready handshake. It sits directly after `dff`. Each sample that `dff` presents on `q` with `in_valid` high is stored in order and released when the consumer is ready. It decouples the capture rate from the consumer rate and flags any sample lost to a full buffer.

---
 rtl/dff_sample_fifo.sv | 105 ++++++++++
 tb/tb_dff_sample_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_sample_fifo.sv
// First-word fall-through sample FIFO placed after the dff capture register.
// Status and head-of-queue outputs are precomputed into flops so they depend only on registered state.
module dff_sample_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             overflow_q, overflow_d;
  logic             push_c;
  logic             pop_c;

  assign push_c = in_valid & in_ready_q;
  assign pop_c  = out_valid_q & out_ready;

  // Next-state for storage, pointers, occupancy and the registered output view.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (in_valid && !in_ready_q) begin
      overflow_d = 1'b1;
    end

    // Reading the post-write array covers the bypass when the new sample becomes the head.
    in_ready_d  = (count_d != CNT_W'(DEPTH));
    out_valid_d = (count_d != CNT_W'(0));
    out_data_d  = out_valid_d ? mem_d[rd_ptr_d] : WIDTH'(0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= WIDTH'(0);
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Sample storage is never cleared; stale entries are masked by out_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_dff_sample_fifo.sv
// Bench for dff_sample_fifo: vector table, directed corner sequences, and random traffic against a queue model.
module tb_dff_sample_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int tests_run;
  int tests_failed;

  dff_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered queue of stored samples plus sticky overflow flag.
  logic [WIDTH-1:0] model_q[$];
  logic             model_ovf;

  typedef struct {
    logic             rst;
    logic             iv;
    logic [WIDTH-1:0] din;
    logic             ordy;
    int               e_cnt;
    logic             e_ir;
    logic             e_ov;
    logic [WIDTH-1:0] e_dat;
    logic             e_ovf;
  } vec_t;

  vec_t tbl[20];

  task automatic model_apply(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    int sz;
    bit do_push;
    bit do_pop;
    sz = model_q.size();
    if (r) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      do_push = iv && (sz < int'(DEPTH));
      do_pop  = ordy && (sz > 0);
      if (iv && sz == int'(DEPTH)) model_ovf = 1'b1;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
  endtask

  // Apply inputs on the falling edge, clock once, return at the next falling edge.
  task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
    reset     = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    model_apply(r, iv, d, ordy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_exp(input string tag, input int e_cnt, input logic e_ir, input logic e_ov,
                           input logic [WIDTH-1:0] e_dat, input logic e_ovf);
    cmp({tag, ".count"},     int'(count),     e_cnt);
    cmp({tag, ".in_ready"},  int'(in_ready),  int'(e_ir));
    cmp({tag, ".out_valid"}, int'(out_valid), int'(e_ov));
    cmp({tag, ".out_data"},  int'(out_data),  int'(e_dat));
    cmp({tag, ".overflow"},  int'(overflow),  int'(e_ovf));
  endtask

  task automatic check_model(input string tag);
    int sz;
    logic [WIDTH-1:0] head;
    sz   = model_q.size();
    head = (sz != 0) ? model_q[0] : WIDTH'(0);
    check_exp(tag, sz, sz != int'(DEPTH), sz != 0, head, model_ovf);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_ovf    = 1'b0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    out_ready    = 1'b0;

    // rst iv din ordy | cnt ir ov dat ovf
    tbl[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 4'h0, 1'b0, 1, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 4'h1, 1'b0, 2, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'h2, 1'b0, 3, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 4'h3, 1'b0, 4, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 4'h4, 1'b0, 5, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 4'h5, 1'b0, 6, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 4'h6, 1'b0, 7, 1'b1, 1'b1, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'h7, 1'b0, 8, 1'b0, 1'b1, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 4'h9, 1'b0, 8, 1'b0, 1'b1, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 7, 1'b1, 1'b1, 4'h1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b1, 6, 1'b1, 1'b1, 4'h2, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b1, 5, 1'b1, 1'b1, 4'h3, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 4, 1'b1, 1'b1, 4'h4, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 3, 1'b1, 1'b1, 4'h5, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 4'h0, 1'b1, 2, 1'b1, 1'b1, 4'h6, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 4'h0, 1'b1, 1, 1'b1, 1'b1, 4'h7, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b1, 0, 1'b1, 1'b0, 4'h0, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 4'h0, 1'b0, 0, 1'b1, 1'b0, 4'h0, 1'b0};

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].din, tbl[i].ordy);
      check_exp($sformatf("vec%0d", i), tbl[i].e_cnt, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_dat, tbl[i].e_ovf);
    end

    // Streaming: after the first cycle occupancy holds at one and the head tracks the last input.
    for (int i = 0; i < 20; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'(i);
      step(1'b0, 1'b1, d, 1'b1);
      cmp($sformatf("stream%0d.count", i), int'(count), 1);
      cmp($sformatf("stream%0d.out_data", i), int'(out_data), int'(d));
    end
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_exp("stream_drain", 0, 1'b1, 1'b0, 4'h0, 1'b0);

    // Simultaneous push and pop at occupancy three.
    step(1'b0, 1'b1, 4'h1, 1'b0);
    step(1'b0, 1'b1, 4'h2, 1'b0);
    step(1'b0, 1'b1, 4'h3, 1'b0);
    check_exp("pp_pre", 3, 1'b1, 1'b1, 4'h1, 1'b0);
    step(1'b0, 1'b1, 4'h4, 1'b1);
    check_exp("pp_post", 3, 1'b1, 1'b1, 4'h2, 1'b0);

    // Full with pop and push offered together: the push is dropped, ready returns one cycle later.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, WIDTH'(i + 5), 1'b0);
    check_exp("full", 8, 1'b0, 1'b1, 4'h2, 1'b0);
    step(1'b0, 1'b1, 4'hE, 1'b1);
    check_exp("full_pop", 7, 1'b1, 1'b1, 4'h3, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_exp("at_five", 5, 1'b1, 1'b1, 4'h5, 1'b1);

    // Reset beats a concurrent push; the pushed sample is not retained.
    step(1'b1, 1'b1, 4'hA, 1'b1);
    check_exp("rst_mid", 0, 1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    check_exp("rst_after", 0, 1'b1, 1'b0, 4'h0, 1'b0);

    // Random traffic in phases biased toward filling, draining and balanced flow.
    for (int c = 0; c < 3000; c++) begin
      int p_in;
      int p_out;
      logic r;
      unique case ((c / 500) % 6)
        0: begin p_in = 80; p_out = 30; end
        1: begin p_in = 30; p_out = 80; end
        2: begin p_in = 50; p_out = 50; end
        3: begin p_in = 90; p_out = 90; end
        4: begin p_in = 70; p_out = 15; end
        default: begin p_in = 15; p_out = 70; end
      endcase
      r = ($urandom_range(0, 299) == 0);
      step(r, $urandom_range(0, 99) < p_in, WIDTH'($urandom), $urandom_range(0, 99) < p_out);
      check_model($sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
